instr_fetch_reg: RTL and testbench
==================================

# instr_fetch_reg

Multi-cycle instruction fetch stage with instruction register. Owns the PC and issues requests to instruction memory with a req/ack handshake. Latches the returned word and presents it, split into MIPS fields, to decode under a valid/ready handshake. Its `imm16` output feeds the zero/sign immediate-extension stage directly; branch/jump redirects arrive from downstream.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_addr` out 32: fetch address; equals PC; stable while `imem_req`=1.
- `imem_ack` in 1: memory returns `imem_rdata` this cycle; may be asserted in the same cycle as `imem_req` (zero-wait memory).
- `imem_rdata` in 32: instruction word, sampled only when `imem_req`=1 and `imem_ack`=1.
- `redirect` in 1: load a new PC; abandons any fetch in flight.
- `redirect_pc` in 32: target PC.
- `out_valid` out 1: held instruction is valid.
- `out_ready` in 1: consumer accepts the held instruction.
- `instr` out 32: raw instruction register.
- `opcode` out 6 [31:26]; `rs` out 5 [25:21]; `rt` out 5 [20:16]; `rd` out 5 [15:11]; `shamt` out 5 [10:6]; `funct` out 6 [5:0].
- `imm16` out 16 [15:0]: raw immediate to the extension stage.
- `jaddr` out 26 [25:0].
- `pc_out` out 32: PC of the held instruction.
- `align_err` out 1: sticky misaligned-redirect flag (see Configuration).

## Operation
- Reset values:
  - state = IDLE, PC = `RESET_PC`.
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `out_valid`=0; `instr` and all field outputs = 0; `pc_out`=0; `align_err`=0.
- States:
  - IDLE: `imem_req`=0, `out_valid`=0. Goes to REQ next cycle.
  - REQ: `imem_req`=1, `imem_addr`=PC. On `imem_ack`: IR <= `imem_rdata`, `pc_out` <= PC, go to HOLD. Without ack: stay in REQ with the request held.
  - HOLD: `out_valid`=1, `imem_req`=0. On `out_ready`: PC <= PC+4, go to REQ.
- Redirect has priority over every other event, in every state:
  - PC <= {`redirect_pc`[31:2],2'b00}; next state is IDLE; `out_valid` is 0 next cycle.
  - REQ with `imem_ack` in the same cycle: the returned word is discarded and the IR is not loaded.
  - HOLD with `out_ready` in the same cycle: the handshake counts as accepted; PC takes the redirect target, not PC+4.
  - IDLE: PC is updated and the block stays in IDLE one more cycle.
- PC+4 wraps modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000); no flag is raised.
- Field outputs are pure slices of the IR; they change only when the IR loads.
- In HOLD, outputs stay stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-operation (any state, any outstanding request) immediately forces the reset values above; any in-flight memory response is ignored.

## Timing
- Zero-wait memory, fetch of one instruction:
  - cycle N: REQ with ack;
  - cycle N+1: `out_valid`=1;
  - cycle N+2 at the earliest: next REQ.
- Peak throughput is one instruction per 2 cycles.
- Memory wait of W cycles adds W cycles to that latency.
- Redirect to first request issued at the new PC: 2 cycles (IDLE, then REQ).
- No combinational path from `out_ready` or `imem_ack` to any output. `imem_req`, `out_valid` and `imem_addr` are registered or decoded from state and PC only.

## Configuration
- `IFETCH_ALIGN_CHECK_EN` defined:
  - a redirect with `redirect_pc`[1:0] != 0 sets `align_err`=1;
  - `align_err` stays set until reset;
  - the PC is still forced word-aligned.
- Not defined: `align_err` is tied to 0 and the low bits of `redirect_pc` are silently dropped. The port exists in both builds.

## Structure
- Shared package `ifetch_pkg` holds:
  - state encoding typedef (IDLE, REQ, HOLD);
  - `PC_STEP`=4;
  - field MSB/LSB constants for opcode, rs, rt, rd, shamt, funct, imm16 and jaddr, which decode and the extension stage reuse.
- One sub-module: `instr_field_split`, a combinational slicer from the 32-bit IR to the field outputs.

## Test plan
- Reset release with `RESET_PC`=0x0000_0040 and a zero-wait memory returning 0x2408_1234: `imem_addr`=0x40 in REQ. Next cycle `out_valid`=1, `opcode`=0x09, `rt`=8, `imm16`=0x1234, `pc_out`=0x40.
- Memory ack delayed 3 cycles: `imem_req` and `imem_addr` stay stable for all 3 cycles, and the IR loads only on ack.
- `out_ready` held low for 5 cycles in HOLD: all outputs stable; PC advances to +4 only when `out_ready` rises.
- Redirect to 0x0000_1000 in the same cycle as `imem_ack`: the returned word is discarded, the next cycle is IDLE, and the following REQ uses `imem_addr`=0x1000.
- PC at 0xFFFF_FFFC accepted: the next fetch is at 0x0000_0000.
- With `IFETCH_ALIGN_CHECK_EN`, redirect to 0x0000_1002: `align_err`=1 and stays 1, and the next fetch is at 0x1000. Without the macro, `align_err` stays 0.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared fetch-stage types and instruction field positions, reused by decode and the imm-extension stage.
// No logic; constants only.
// No flow control.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_HOLD = 2'd2
    } ifetch_state_e;

    localparam logic [31:0] PC_STEP = 32'd4;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM16_MSB  = 15;
    localparam int unsigned IMM16_LSB  = 0;
    localparam int unsigned JADDR_MSB  = 25;
    localparam int unsigned JADDR_LSB  = 0;

endpackage

// File: rtl/instr_field_split.sv
// Slices a 32-bit MIPS instruction word into its R/I/J-format fields.
// Latency: purely combinational.
// Backpressure: none; follows its input.
module instr_field_split
    import ifetch_pkg::*;
(
    input  logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr
);

    assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
    assign rs     = instr[RS_MSB:RS_LSB];
    assign rt     = instr[RT_MSB:RT_LSB];
    assign rd     = instr[RD_MSB:RD_LSB];
    assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
    assign imm16  = instr[IMM16_MSB:IMM16_LSB];
    assign jaddr  = instr[JADDR_MSB:JADDR_LSB];

endmodule

// File: rtl/instr_fetch_reg.sv
// Multi-cycle fetch stage: owns the PC, fetches via req/ack, holds the word in an IR for decode.
// Latency: ack cycle -> out_valid next cycle; redirect -> new REQ after one IDLE cycle.
// Backpressure: HOLD until out_ready; redirect wins over everything. IFETCH_ALIGN_CHECK_EN enables align_err.
module instr_fetch_reg
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] pc_out,
    output logic        align_err
);

    ifetch_state_e r_state;
    ifetch_state_e w_state_nxt;
    logic [31:0]   r_pc;
    logic [31:0]   w_pc_nxt;
    logic [31:0]   r_ir;
    logic [31:0]   r_pc_out;
    logic          w_ir_load;
    logic [31:0]   w_redirect_pc_al;

    assign w_redirect_pc_al = {redirect_pc[31:2], 2'b00};

    // Redirect drops any returned word and any pending handshake; PC wraps naturally at 2^32.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ir_load   = 1'b0;
        if (redirect) begin
            w_state_nxt = ST_IDLE;
            w_pc_nxt    = w_redirect_pc_al;
        end else begin
            case (r_state)
                ST_IDLE: w_state_nxt = ST_REQ;
                ST_REQ: begin
                    if (imem_ack) begin
                        w_ir_load   = 1'b1;
                        w_state_nxt = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        w_pc_nxt    = r_pc + PC_STEP;
                        w_state_nxt = ST_REQ;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ir     <= 32'h0;
            r_pc_out <= 32'h0;
        end else if (w_ir_load) begin
            r_ir     <= imem_rdata;
            r_pc_out <= r_pc;
        end
    end

    assign imem_req  = (r_state == ST_REQ);
    assign imem_addr = r_pc;
    assign out_valid = (r_state == ST_HOLD);
    assign instr     = r_ir;
    assign pc_out    = r_pc_out;

    instr_field_split u_field_split (
        .instr  (r_ir),
        .opcode (opcode),
        .rs     (rs),
        .rt     (rt),
        .rd     (rd),
        .shamt  (shamt),
        .funct  (funct),
        .imm16  (imm16),
        .jaddr  (jaddr)
    );

`ifdef IFETCH_ALIGN_CHECK_EN
    logic r_align_err;

    // Sticky until reset; the PC itself is still forced word-aligned above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_align_err <= 1'b0;
        end else if (redirect && (redirect_pc[1:0] != 2'b00)) begin
            r_align_err <= 1'b1;
        end
    end

    assign align_err = r_align_err;
`else
    logic w_unused_lsbs;

    assign w_unused_lsbs = ^redirect_pc[1:0];
    assign align_err     = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_reg.sv
// Scoreboard bench for instr_fetch_reg: acked words are queued with their PC and checked when decode accepts them.
module tb_instr_fetch_reg;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jaddr;
    logic [31:0] pc_out;
    logic        align_err;

    always #5 clk = ~clk;

    instr_fetch_reg #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .instr       (instr),
        .opcode      (opcode),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .shamt       (shamt),
        .funct       (funct),
        .imm16       (imm16),
        .jaddr       (jaddr),
        .pc_out      (pc_out),
        .align_err   (align_err)
    );

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } exp_t;

    exp_t        sb[$];
    int          n_vec = 0;
    int          n_miscmp = 0;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        exp_align;

    task automatic chk_vec(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'h2408_1234;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Called on a falling edge while the DUT is in REQ; leaves off on the edge where HOLD is visible.
    task automatic serve(input int w);
        logic [31:0] d;
        chk_vec("req_on", imem_req, 1);
        chk_vec("req_addr", imem_addr, m_pc);
        for (int i = 0; i < w; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            chk_vec("wait_req", imem_req, 1);
            chk_vec("wait_addr", imem_addr, m_pc);
            chk_vec("wait_ir", instr, m_ir);
            chk_vec("wait_vld", out_valid, 0);
        end
        d = mem_word(m_pc);
        imem_ack   = 1'b1;
        imem_rdata = d;
        sb.push_back('{ins: d, pc: m_pc});
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    task automatic check_held(input exp_t e);
        chk_vec("vld_on", out_valid, 1);
        chk_vec("hold_req", imem_req, 0);
        chk_vec("instr", instr, e.ins);
        chk_vec("pc_out", pc_out, e.pc);
        chk_vec("opcode", opcode, e.ins[31:26]);
        chk_vec("rs", rs, e.ins[25:21]);
        chk_vec("rt", rt, e.ins[20:16]);
        chk_vec("rd", rd, e.ins[15:11]);
        chk_vec("shamt", shamt, e.ins[10:6]);
        chk_vec("funct", funct, e.ins[5:0]);
        chk_vec("imm16", imm16, e.ins[15:0]);
        chk_vec("jaddr", jaddr, e.ins[25:0]);
    endtask

    // Called in HOLD; stalls h cycles, then accepts. Leaves off on the edge where the next REQ is visible.
    task automatic consume(input int h);
        exp_t e;
        chk_vec("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        e    = sb.pop_front();
        m_ir = e.ins;
        check_held(e);
        for (int i = 0; i < h; i++) begin
            out_ready = 1'b0;
            @(negedge clk);
            chk_vec("stall_vld", out_valid, 1);
            chk_vec("stall_instr", instr, e.ins);
            chk_vec("stall_pc", pc_out, e.pc);
            chk_vec("stall_req", imem_req, 0);
            chk_vec("stall_addr", imem_addr, m_pc);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        m_pc      = m_pc + 32'd4;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        exp_t e;
`ifdef IFETCH_ALIGN_CHECK_EN
        exp_align = 1'b1;
`else
        exp_align = 1'b0;
`endif
        rst_n       = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        out_ready   = 1'b0;
        m_pc        = RST_PC;
        m_ir        = 32'h0;
        repeat (2) @(negedge clk);
        chk_vec("rst_req", imem_req, 0);
        chk_vec("rst_addr", imem_addr, RST_PC);
        chk_vec("rst_vld", out_valid, 0);
        chk_vec("rst_instr", instr, 0);
        chk_vec("rst_jaddr", jaddr, 0);
        chk_vec("rst_pc_out", pc_out, 0);
        chk_vec("rst_align", align_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Zero-wait fetch of the known word at the reset PC.
        serve(0);
        chk_vec("t1_opcode", opcode, 32'h09);
        chk_vec("t1_rt", rt, 32'h8);
        chk_vec("t1_imm16", imm16, 32'h1234);
        chk_vec("t1_pc_out", pc_out, 32'h40);
        consume(0);

        // Three wait cycles, then five stalled cycles in HOLD.
        serve(3);
        consume(5);

        // Redirect coinciding with ack: word discarded, IDLE, then REQ at target.
        imem_ack    = 1'b1;
        imem_rdata  = 32'hFFFF_0000;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1000;
        @(negedge clk);
        imem_ack = 1'b0;
        redirect = 1'b0;
        m_pc     = 32'h0000_1000;
        chk_vec("rdr_idle_req", imem_req, 0);
        chk_vec("rdr_idle_vld", out_valid, 0);
        chk_vec("rdr_ir_kept", instr, m_ir);
        @(negedge clk);
        serve(0);

        // Redirect together with out_ready in HOLD: accepted, PC goes to target not PC+4.
        chk_vec("hr_depth", sb.size(), 1);
        if (sb.size() != 0) begin
            e    = sb.pop_front();
            m_ir = e.ins;
            check_held(e);
        end
        out_ready   = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_2000;
        @(negedge clk);
        out_ready = 1'b0;
        chk_vec("hr_vld_off", out_valid, 0);
        chk_vec("hr_addr", imem_addr, 32'h0000_2000);
        // Redirect again while IDLE: stays IDLE one more cycle.
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect = 1'b0;
        m_pc     = 32'hFFFF_FFFC;
        chk_vec("idle_rdr_req", imem_req, 0);
        chk_vec("idle_rdr_addr", imem_addr, m_pc);
        @(negedge clk);
        serve(0);
        consume(1);
        chk_vec("wrap_addr", imem_addr, 32'h0);
        serve(0);
        consume(0);

        // Misaligned redirect target.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_1002;
        @(negedge clk);
        redirect = 1'b0;
        m_pc     = 32'h0000_1000;
        chk_vec("align_set", align_err, exp_align);
        @(negedge clk);
        serve(1);
        consume(2);
        chk_vec("align_sticky", align_err, exp_align);

        for (int k = 0; k < 20; k++) begin
            serve(int'($urandom_range(0, 3)));
            consume(int'($urandom_range(0, 3)));
        end

        // Asynchronous reset during an outstanding request with a response arriving.
        imem_ack = 1'b0;
        @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = 32'h1234_5678;
        rst_n      = 1'b0;
        #1;
        chk_vec("mrst_req", imem_req, 0);
        chk_vec("mrst_addr", imem_addr, RST_PC);
        chk_vec("mrst_vld", out_valid, 0);
        chk_vec("mrst_instr", instr, 0);
        chk_vec("mrst_pc_out", pc_out, 0);
        chk_vec("mrst_align", align_err, 0);
        @(negedge clk);
        chk_vec("mrst_hold_instr", instr, 0);
        imem_ack = 1'b0;
        rst_n    = 1'b1;
        sb.delete();
        m_pc = RST_PC;
        m_ir = 32'h0;
        @(negedge clk);
        serve(2);
        consume(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
